fifo_rr_arbiter: RTL and testbench
==================================

Name: fifo_rr_arbiter

Overview:
- Round-robin read scheduler that drains N small-FIFO channels into one shared median-operator input stream.
- Each channel drives the FIFO read side: active-high empty and combinational dataout, with a read enable that pops the head on the next clock.
- Grants are held for up to BURST words per channel.
- The output is a single registered valid/ready stage tagged with the source channel id.

Parameters:
N, 4, number of FIFO channels (>=2)
size, 8, data width per word
BURST, 4, maximum words popped per grant (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
en  input  1  high = new grants allowed; low = no new grant, current burst completes
fifo_empty  input  N  per-channel FIFO empty flag, bit i = channel i
fifo_data  input  N*size  concatenated FIFO heads, channel i at [i*size +: size]
fifo_enr  output  N  per-channel pop strobe, combinational, at most one bit high
out_data  output  size  registered word
out_ch  output  clog2(N)  channel id of out_data
out_valid  output  1  out_data/out_ch valid
out_ready  input  1  downstream accepts when out_valid && out_ready
busy  output  1  high while state = BURST
grant_id  output  clog2(N)  currently/last granted channel

Behaviour:
- Reset (rst=1, async):
  - state=IDLE, rr_ptr=0, grant_id=0, cnt=0.
  - out_valid=0, out_data=0, out_ch=0.
  - fifo_enr=0, busy=0.
  - A mid-burst reset drops the held word; any pop in flight is not issued.
- States:
  - IDLE: if en and any fifo_empty bit is 0, grant_id <= first non-empty channel searching rr_ptr, rr_ptr+1, ... wrapping mod N; cnt <= 0; go to BURST. Otherwise stay in IDLE.
  - BURST:
    - pop = !fifo_empty[grant_id] && (!out_valid || out_ready).
    - On pop: fifo_enr[grant_id]=1 in the same cycle; out_data <= fifo_data[grant_id]; out_ch <= grant_id; out_valid <= 1; cnt <= cnt+1.
    - Exit to IDLE when (pop && cnt==BURST-1) or fifo_empty[grant_id]=1. On exit, rr_ptr <= (grant_id+1) mod N.
- Output stage:
  - If no pop and out_ready, out_valid <= 0.
  - While out_valid && !out_ready, out_data and out_ch hold stable and no pop occurs.
  - Full throughput: one word per cycle during a burst when out_ready=1.
- Latency:
  - Grant decision takes 1 cycle (IDLE).
  - First pop occurs in the first BURST cycle; the word appears on out_data the next cycle.
  - Minimum 1 idle cycle between consecutive bursts.
- fifo_enr is never asserted for an empty channel, in IDLE, or while stalled.
- A channel going empty mid-burst ends the burst early; the pointer still advances.
- en deasserted mid-burst has no effect until the return to IDLE.
- Widths: cnt is clog2(BURST+1) bits. rr_ptr and grant_id wrap from N-1 to 0, correct for non-power-of-two N.

Optional Feature:
- Macro: ARB_PRIO_EN.
- Defined:
  - Channel 0 is high priority. In IDLE, if en and !fifo_empty[0], grant channel 0 regardless of rr_ptr.
  - A burst on channel 0 leaves rr_ptr unchanged, unless channel 0 was also the round-robin choice.
  - Active bursts are never preempted.
- Undefined: pure round-robin as above; channel 0 has no special treatment.

Test Plan:
- Reset: assert rst mid-burst with out_valid=1 -> same cycle out_valid=0, fifo_enr=0, busy=0; after release the first grant goes to channel 0.
- Fairness (N=4, BURST=4): all channels preloaded with 8 words, out_ready=1 -> out_ch sequence 0x4,1x4,2x4,3x4,0x4,...; 1 gap cycle between bursts; 32 words total, no loss or duplication.
- Short burst: channel 1 holds 2 words, others empty, rr_ptr=1 -> exactly 2 pops, busy deasserts, rr_ptr=2, next grant to the next non-empty channel.
- Backpressure: out_ready=0 for 5 cycles mid-burst -> out_data/out_ch stable, fifo_enr=0 throughout; upon out_ready=1 the stream resumes with no word dropped.
- Enable gating: en=0 with words present -> no grant, busy=0; en dropped mid-burst -> burst completes its 4 words, then stays in IDLE.
- ARB_PRIO_EN: channels 0 and 2 non-empty, rr_ptr=2 -> grant 0 first, then 2; rr_ptr not advanced by the channel-0 burst.

Source files
------------

// File: rtl/fifo_rr_arbiter.sv
// Round-robin read scheduler: drains N FIFO channels into a single registered
// valid/ready output stage tagged with the source channel id. Each grant is held
// for at most BURST pops, or until the granted channel runs empty.
//
// Optional feature, compile-time macro ARB_PRIO_EN:
//   defined   - channel 0 wins every grant decision it requests. A channel-0 burst
//               that was not also the round-robin choice leaves the pointer alone.
//   undefined - pure round-robin, no special treatment of channel 0.
module fifo_rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned size  = 8,
  parameter int unsigned BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N-1:0]         fifo_empty,
  input  logic [N*size-1:0]    fifo_data,
  output logic [N-1:0]         fifo_enr,
  output logic [size-1:0]      out_data,
  output logic [$clog2(N)-1:0] out_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int unsigned IdW  = $clog2(N);
  localparam int unsigned CntW = $clog2(BURST + 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e          r_state;
  logic            r_busy;
  logic [IdW-1:0]  r_rr_ptr;
  logic [IdW-1:0]  r_grant_id;
  logic [CntW-1:0] r_cnt;
  logic            r_out_valid;
  logic [size-1:0] r_out_data;
  logic [IdW-1:0]  r_out_ch;

  logic            w_rr_found;
  logic [IdW-1:0]  w_rr_choice;
  logic [IdW-1:0]  w_pick;
  logic            w_rr_adv;
  logic            w_grant_empty;
  logic [size-1:0] w_head;
  logic            w_pop;
  logic            w_last_pop;
  logic            w_exit;
  logic [IdW-1:0]  w_next_id;

  assign w_grant_empty = fifo_empty[r_grant_id];
  assign w_head        = fifo_data[r_grant_id*size +: size];

  // A pop needs data at the head and room in the output register.
  assign w_pop      = (r_state == StBurst) && !w_grant_empty && (!r_out_valid || out_ready);
  assign w_last_pop = w_pop && (r_cnt == CntW'(BURST - 1));
  assign w_exit     = (r_state == StBurst) && (w_last_pop || w_grant_empty);

  // Explicit wrap so non-power-of-two N never lands on an unused id.
  assign w_next_id = (r_grant_id == IdW'(N - 1)) ? '0 : r_grant_id + IdW'(1);

  // Round-robin search: first non-empty channel starting at the pointer.
  always_comb begin
    int unsigned idx;
    w_rr_found  = 1'b0;
    w_rr_choice = r_rr_ptr;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(r_rr_ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!w_rr_found && !fifo_empty[IdW'(idx)]) begin
        w_rr_found  = 1'b1;
        w_rr_choice = IdW'(idx);
      end
    end
  end

`ifdef ARB_PRIO_EN
  logic r_rr_adv;
  logic w_rr_adv_new;

  // Channel 0 overrides the round-robin choice whenever it has data.
  assign w_pick       = !fifo_empty[0] ? '0 : w_rr_choice;
  // Only advance the pointer if this grant is what round-robin would have picked.
  assign w_rr_adv_new = fifo_empty[0] || (w_rr_choice == '0);
  assign w_rr_adv     = r_rr_adv;

  // Remember at grant time whether the burst's exit should move the pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_adv <= 1'b1;
    end else if ((r_state == StIdle) && en && w_rr_found) begin
      r_rr_adv <= w_rr_adv_new;
    end
  end
`else
  assign w_pick   = w_rr_choice;
  assign w_rr_adv = 1'b1;
`endif

  // Pop strobe is combinational: at most the granted channel, only on a real pop.
  always_comb begin
    fifo_enr = '0;
    if (w_pop) begin
      fifo_enr[r_grant_id] = 1'b1;
    end
  end

  // Grant FSM with registered busy, grant id, burst counter and output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_busy      <= 1'b0;
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else begin
      // Output register: load on pop, drain on accept, otherwise hold.
      if (w_pop) begin
        r_out_data  <= w_head;
        r_out_ch    <= r_grant_id;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        StIdle: begin
          if (en && w_rr_found) begin
            r_grant_id <= w_pick;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_state    <= StBurst;
          end
        end
        StBurst: begin
          if (w_pop) begin
            r_cnt <= r_cnt + CntW'(1);
          end
          // en is deliberately ignored here: a running burst always completes.
          if (w_exit) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
            if (w_rr_adv) begin
              r_rr_ptr <= w_next_id;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench for fifo_rr_arbiter: queue-backed FIFO channels, a
// transaction-level scheduler model, directed scenarios and a random phase.
module tb_fifo_rr_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned SIZE  = 8;
  localparam int unsigned BURST = 4;
  localparam int unsigned IDW   = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            out_ready;
  logic [N-1:0]    fifo_empty;
  logic [N*SIZE-1:0] fifo_data;
  logic [N-1:0]    fifo_enr;
  logic [SIZE-1:0] out_data;
  logic [IDW-1:0]  out_ch;
  logic            out_valid;
  logic            busy;
  logic [IDW-1:0]  grant_id;

  always #5 clk = ~clk;

  fifo_rr_arbiter #(
    .N    (N),
    .size (SIZE),
    .BURST(BURST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_enr  (fifo_enr),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  // Channel FIFO contents, head at index 0.
  logic [SIZE-1:0] q [N][$];

  // Scheduler model: m_gnt = -1 when no grant is held.
  int              m_gnt, m_ptr, m_taken, m_last, m_och;
  bit              m_adv, m_ov;
  logic [SIZE-1:0] m_od;

  int total, bad;
  int n_push, n_acc, n_drop;
  int dut_pops [N];
  int acc_ch [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      q[ch].push_back(SIZE'($urandom));
      n_push++;
    end
  endtask

  task automatic drive_fifo();
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = (q[i].size() == 0);
      fifo_data[i*SIZE +: SIZE] = (q[i].size() != 0) ? q[i][0] : '0;
    end
  endtask

  task automatic model_reset();
    m_gnt = -1; m_ptr = 0; m_taken = 0; m_last = 0;
    m_och = 0; m_adv = 1'b1; m_ov = 1'b0; m_od = '0;
  endtask

  function automatic int pops_total();
    int s = 0;
    for (int i = 0; i < N; i++) s += dut_pops[i];
    return s;
  endfunction

  // One clock: drive inputs, compare DUT with model, then advance the model.
  task automatic step(input bit en_v, input bit rdy_v, input bit do_rst);
    int pop_ch, rr, c;
    bit was_empty;
    logic [N-1:0] exp_enr;
    @(negedge clk);
    rst = 1'b0;
    en = en_v;
    out_ready = rdy_v;
    drive_fifo();
    #1;
    pop_ch = -1;
    if (m_gnt >= 0 && q[m_gnt].size() > 0 && (!m_ov || rdy_v)) pop_ch = m_gnt;
    exp_enr = '0;
    if (pop_ch >= 0) exp_enr[pop_ch] = 1'b1;
    check("fifo_enr", fifo_enr, exp_enr);
    check("busy", busy, m_gnt >= 0);
    check("out_valid", out_valid, m_ov);
    if (m_ov) begin
      check("out_data", out_data, m_od);
      check("out_ch", out_ch, m_och);
    end
    check("grant_id", grant_id, m_last);
    if (do_rst) begin
      if (out_valid) n_drop++;
      rst = 1'b1;
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_enr", fifo_enr, 0);
      check("rst_busy", busy, 0);
      check("rst_data", out_data, 0);
      check("rst_ch", out_ch, 0);
      check("rst_grant", grant_id, 0);
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) if (fifo_enr[i]) dut_pops[i]++;
    if (out_valid && rdy_v) begin
      n_acc++;
      acc_ch.push_back(int'(out_ch));
    end
    if (m_gnt >= 0) begin
      was_empty = (q[m_gnt].size() == 0);
      if (pop_ch >= 0) begin
        m_od = q[m_gnt].pop_front();
        m_och = m_gnt;
        m_ov = 1'b1;
        m_taken++;
      end else if (rdy_v) begin
        m_ov = 1'b0;
      end
      if (was_empty || m_taken == BURST) begin
        if (m_adv) m_ptr = (m_gnt + 1) % N;
        m_gnt = -1;
      end
    end else begin
      if (rdy_v) m_ov = 1'b0;
      rr = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (rr < 0 && q[c].size() > 0) rr = c;
      end
      if (en_v && rr >= 0) begin
        m_gnt = rr;
        m_adv = 1'b1;
`ifdef ARB_PRIO_EN
        if (q[0].size() > 0) begin
          m_gnt = 0;
          m_adv = (rr == 0);
        end
`endif
        m_last = m_gnt;
        m_taken = 0;
      end
    end
  endtask

  function automatic bit all_idle();
    bit r = (m_gnt < 0) && !m_ov;
    for (int i = 0; i < N; i++) if (q[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  initial begin
    int p0, cyc;
    bit rst_done;
    total = 0; bad = 0; n_push = 0; n_acc = 0; n_drop = 0;
    for (int i = 0; i < N; i++) dut_pops[i] = 0;
    model_reset();
    rst = 1'b1; en = 1'b0; out_ready = 1'b0;
    fifo_empty = '1; fifo_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_enr", fifo_enr, 0);
    check("reset_grant", grant_id, 0);
    check("reset_data", out_data, 0);
    check("reset_ch", out_ch, 0);

    // Fairness: every channel preloaded, full throughput.
    for (int ch = 0; ch < N; ch++) push(ch, 8);
    acc_ch.delete();
    for (int i = 0; i < 50; i++) step(1'b1, 1'b1, 1'b0);
    check("fair_count", acc_ch.size(), 32);
`ifndef ARB_PRIO_EN
    for (int k = 0; k < acc_ch.size() && k < 32; k++) check("fair_seq", acc_ch[k], (k / 4) % 4);
`endif

    // Short burst: move pointer to 1, then channel 1 holds only 2 words.
    push(0, 1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
    push(1, 2);
    push(3, 3);
    p0 = dut_pops[1];
    acc_ch.delete();
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0);
    check("short_pops", dut_pops[1] - p0, 2);
    check("short_order_len", acc_ch.size(), 5);
    if (acc_ch.size() == 5) begin
      check("short_order1", acc_ch[1], 1);
      check("short_next", acc_ch[2], 3);
    end

    // Backpressure: stall 5 cycles mid-burst.
    push(2, 6);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    p0 = pops_total();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    check("stall_pops", pops_total() - p0, 0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0);

    // Enable gating: no grant while en=0, running burst completes after en drops.
    push(1, 4);
    push(3, 4);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
    check("en_off_busy", busy, 0);
    p0 = pops_total();
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);
    check("en_drop_pops", pops_total() - p0, 4);
    check("en_drop_busy", busy, 0);

    // Random traffic, with one reset landing mid-burst while a word is held.
    rst_done = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        cyc = $urandom_range(0, N - 1);
        if (q[cyc].size() < 10) push(cyc, $urandom_range(1, 3));
      end
      if (i >= 700 && !rst_done && m_gnt >= 0 && m_ov) begin
        if (q[0].size() == 0) push(0, 2);
        step(1'b1, 1'b1, 1'b1);
        rst_done = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("rst_first_grant", grant_id, 0);
      end else begin
        step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, 1'b0);
      end
    end
    check("rst_event", rst_done, 1);

    // Drain everything and check conservation of words.
    cyc = 0;
    while (!all_idle() && cyc < 400) begin
      step(1'b1, 1'b1, 1'b0);
      cyc++;
    end
    check("drain_done", all_idle(), 1);
    check("conservation", n_acc + n_drop, n_push);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
